// File: rtl/rfm_scheduler_if.sv
// -----------------------------------------------------------------------------
// rfm_scheduler_if
//   Bundles the ACT command input and the RFM issue/status outputs of
//   rfm_scheduler.
//   master : command source (memory controller / testbench)
//   slave  : rfm_scheduler
// Signals:
//   act_cmd    one-cycle ACT strobe
//   act_bank   bank targeted by act_cmd
//   rfm_cmd    one-hot, one-cycle RFM pulse to the granted bank
//   rfm_bank   index of the current or last granted bank
//   busy       shared RFM resource occupied
//   act_block  per-bank "ACT not allowed"
//   act_err    one-cycle pulse: previous-cycle ACT hit a blocked bank
// -----------------------------------------------------------------------------
interface rfm_scheduler_if #(
  parameter int NUM_BANK  = 4,
  parameter int BANK_BITS = 2
);
  logic                 act_cmd;
  logic [BANK_BITS-1:0] act_bank;
  logic [NUM_BANK-1:0]  rfm_cmd;
  logic [BANK_BITS-1:0] rfm_bank;
  logic                 busy;
  logic [NUM_BANK-1:0]  act_block;
  logic                 act_err;

  modport master (
    output act_cmd, act_bank,
    input  rfm_cmd, rfm_bank, busy, act_block, act_err
  );

  modport slave (
    input  act_cmd, act_bank,
    output rfm_cmd, rfm_bank, busy, act_block, act_err
  );
endinterface

// File: rtl/rfm_scheduler.sv
// -----------------------------------------------------------------------------
// rfm_scheduler
//   Multi-bank RFM issue controller. Tracks a rolling accumulated activation
//   (RAA) count per bank, grants the shared RFM slot round-robin to banks at or
//   above RFM_TH, pulses that bank's rfm_cmd for one cycle and then holds the
//   resource busy for T_RFM cycles. Banks at the RAA ceiling, and the bank
//   under RFM, are blocked from further activations.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   rfm_scheduler_if.slave (act_cmd/act_bank in; rfm_cmd, rfm_bank,
//         busy, act_block, act_err out)
// -----------------------------------------------------------------------------
module rfm_scheduler #(
  parameter int NUM_BANK  = 4,
  parameter int BANK_BITS = 2,
  parameter int RFM_TH    = 20,
  parameter int RAA_MAX   = 40,
  parameter int RAA_BITS  = 8,
  parameter int T_RFM     = 60,
  parameter int T_BITS    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  rfm_scheduler_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [RAA_BITS-1:0] TH_W   = RAA_BITS'(RFM_TH);
  localparam logic [RAA_BITS-1:0] MAX_W  = RAA_BITS'(RAA_MAX);
  localparam logic [T_BITS-1:0]   TRFM_W = T_BITS'(T_RFM);

  logic [1:0]           state;
  logic [RAA_BITS-1:0]  raa [NUM_BANK];
  logic [BANK_BITS-1:0] ptr;
  logic [BANK_BITS-1:0] rfm_bank_q;
  logic [T_BITS-1:0]    wait_cnt;
  logic                 act_err_q;

  logic [NUM_BANK-1:0]  req;
  logic [NUM_BANK-1:0]  act_block;
  logic [NUM_BANK-1:0]  rfm_cmd;
  logic                 busy;
  logic                 act_ok;
  logic                 act_hit_block;
  logic                 grant_vld;
  logic [BANK_BITS-1:0] grant_idx;
  logic [BANK_BITS-1:0] cand;

  assign busy = (state != ST_IDLE);

  // Request and block flags come straight from registered state so they
  // reflect an ACT one cycle after it was accepted.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      req[b]       = (raa[b] >= TH_W);
      act_block[b] = (raa[b] >= MAX_W) || (busy && (rfm_bank_q == BANK_BITS'(b)));
    end
  end

  assign act_ok        = bus.act_cmd && !act_block[bus.act_bank];
  assign act_hit_block = bus.act_cmd &&  act_block[bus.act_bank];

  // Round-robin search starting just after the last granted bank; the
  // BANK_BITS-wide add wraps modulo NUM_BANK.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int i = 1; i <= NUM_BANK; i++) begin
      cand = ptr + BANK_BITS'(i);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rfm_cmd is decoded from the ISSUE state, so it can never be multi-hot or
  // outlive ISSUE, and it drops with the asynchronous reset.
  always_comb begin
    rfm_cmd = '0;
    if (state == ST_ISSUE) rfm_cmd[rfm_bank_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      ptr        <= BANK_BITS'(NUM_BANK - 1);
      rfm_bank_q <= '0;
      wait_cnt   <= '0;
      act_err_q  <= 1'b0;
    end else begin
      act_err_q <= act_hit_block;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            rfm_bank_q <= grant_idx;
            ptr        <= grant_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= TRFM_W;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - T_BITS'(1);
          if (wait_cnt == T_BITS'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the RAA array is real control state (it drives req/act_block), so
  // unlike a data memory it must be cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NUM_BANK; b++) raa[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        // The granted bank is blocked during ISSUE, so the subtract never
        // competes with an increment on the same bank.
        if ((state == ST_ISSUE) && (rfm_bank_q == BANK_BITS'(b))) begin
          raa[b] <= raa[b] - TH_W;
        end else if (act_ok && (bus.act_bank == BANK_BITS'(b)) && (raa[b] < MAX_W)) begin
          raa[b] <= raa[b] + RAA_BITS'(1);
        end
      end
    end
  end

  assign bus.rfm_cmd   = rfm_cmd;
  assign bus.rfm_bank  = rfm_bank_q;
  assign bus.busy      = busy;
  assign bus.act_block = act_block;
  assign bus.act_err   = act_err_q;

endmodule

// File: tb/tb_rfm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rfm_scheduler
//   Directed bench for rfm_scheduler with default parameters
//   (4 banks, RFM_TH=20, RAA_MAX=40, T_RFM=60). Inputs are driven and outputs
//   sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_rfm_scheduler;

  logic clk;
  logic rstn;
  int   n_assert;
  int   n_fail;
  int   cyc;

  rfm_scheduler_if #(.NUM_BANK(4), .BANK_BITS(2)) bus ();

  rfm_scheduler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_act(input logic [1:0] bank);
    bus.act_cmd  = 1'b1;
    bus.act_bank = bank;
    tick();
    bus.act_cmd  = 1'b0;
  endtask

  task automatic do_reset();
    bus.act_cmd  = 1'b0;
    bus.act_bank = 2'd0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Advance until rfm_cmd is non-zero, bounded so a stuck DUT cannot hang.
  task automatic wait_rfm(output logic [3:0] cmd);
    int t0;
    t0 = cyc;
    while (bus.rfm_cmd == 4'b0000 && (cyc - t0) < 300) tick();
    cmd = bus.rfm_cmd;
  endtask

  task automatic test_reset();
    bus.act_cmd  = 1'b0;
    bus.act_bank = 2'd0;
    rstn = 1'b0;
    #3;
    tick();
    n_assert++;
    if ({bus.rfm_cmd, bus.rfm_bank, bus.busy, bus.act_block, bus.act_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd=%b bank=%0d busy=%b blk=%b err=%b, want all 0",
               bus.rfm_cmd, bus.rfm_bank, bus.busy, bus.act_block, bus.act_err);
    end
    for (int b = 0; b < 4; b++) begin
      n_assert++;
      if (dut.raa[b] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_raa%0d: got %0d want 0", b, dut.raa[b]);
      end
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_threshold();
    int n;
    int bad;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      do_act(2'd1);
      tick();
    end
    do_act(2'd1);
    n_assert++;
    if (bus.rfm_cmd !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_grant_cycle: got cmd=%b busy=%b want 0000/0", bus.rfm_cmd, bus.busy);
    end
    tick();
    n_assert++;
    if (bus.rfm_cmd !== 4'b0010 || bus.rfm_bank !== 2'd1) begin
      n_fail++;
      $display("FAIL thr_issue: got cmd=%b bank=%0d want 0010/1", bus.rfm_cmd, bus.rfm_bank);
    end
    n = 0;
    bad = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.act_block[1] !== 1'b1) bad++;
      if (n > 0 && bus.rfm_cmd !== 4'b0000) bad++;
      n++;
      tick();
    end
    n_assert++;
    if (n !== 61) begin
      n_fail++;
      $display("FAIL thr_busy_len: got %0d cycles want 61", n);
    end
    n_assert++;
    if (bad !== 0 || bus.act_block[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_block_pulse: got %0d bad cycles blk1_after=%b want 0/0", bad, bus.act_block[1]);
    end
    n_assert++;
    if (dut.raa[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL thr_raa1: got %0d want 0", dut.raa[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] cmd;
    int t_prev;
    do_reset();
    for (int i = 0; i < 20; i++) do_act(2'd3);
    tick();
    n_assert++;
    if (bus.rfm_cmd !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_pre_issue: got %b want 1000", bus.rfm_cmd);
    end
    // Bring banks 0 and 2 to threshold while bank 3 holds the resource.
    for (int i = 0; i < 20; i++) begin
      do_act(2'd0);
      do_act(2'd2);
    end
    wait_rfm(cmd);
    t_prev = cyc;
    n_assert++;
    if (cmd !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_first: got %b want 0001", cmd);
    end
    // Push bank 2 to 40 so it still requests after its own RFM.
    for (int i = 0; i < 20; i++) do_act(2'd2);
    wait_rfm(cmd);
    n_assert++;
    if (cmd !== 4'b0100 || (cyc - t_prev) !== 62) begin
      n_fail++;
      $display("FAIL rr_second: got %b after %0d want 0100 after 62", cmd, cyc - t_prev);
    end
    t_prev = cyc;
    for (int i = 0; i < 20; i++) do_act(2'd0);
    wait_rfm(cmd);
    n_assert++;
    if (cmd !== 4'b0001 || (cyc - t_prev) !== 62) begin
      n_fail++;
      $display("FAIL rr_tie_after2: got %b after %0d want 0001 after 62", cmd, cyc - t_prev);
    end
    t_prev = cyc;
    tick();
    wait_rfm(cmd);
    n_assert++;
    if (cmd !== 4'b0100 || (cyc - t_prev) !== 62) begin
      n_fail++;
      $display("FAIL rr_fourth: got %b after %0d want 0100 after 62", cmd, cyc - t_prev);
    end
  endtask

  task automatic test_ceiling();
    logic [3:0] cmd;
    int t_prev;
    do_reset();
    for (int i = 0; i < 20; i++) do_act(2'd0);
    tick();
    for (int i = 0; i < 39; i++) do_act(2'd3);
    n_assert++;
    if (bus.act_block[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL ceil_39_block: got %b want 0", bus.act_block[3]);
    end
    do_act(2'd3);
    n_assert++;
    if (bus.act_block[3] !== 1'b1 || dut.raa[3] !== 8'd40) begin
      n_fail++;
      $display("FAIL ceil_40: got blk=%b raa=%0d want 1/40", bus.act_block[3], dut.raa[3]);
    end
    do_act(2'd3);
    n_assert++;
    if (bus.act_err !== 1'b1 || dut.raa[3] !== 8'd40) begin
      n_fail++;
      $display("FAIL ceil_41_err: got err=%b raa=%0d want 1/40", bus.act_err, dut.raa[3]);
    end
    tick();
    n_assert++;
    if (bus.act_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ceil_err_width: got %b want 0", bus.act_err);
    end
    wait_rfm(cmd);
    t_prev = cyc;
    tick();
    n_assert++;
    if (cmd !== 4'b1000 || dut.raa[3] !== 8'd20) begin
      n_fail++;
      $display("FAIL ceil_rfm1: got cmd=%b raa=%0d want 1000/20", cmd, dut.raa[3]);
    end
    wait_rfm(cmd);
    n_assert++;
    if (cmd !== 4'b1000 || (cyc - t_prev) !== 62) begin
      n_fail++;
      $display("FAIL ceil_rfm2: got %b after %0d want 1000 after 62", cmd, cyc - t_prev);
    end
    tick();
    n_assert++;
    if (dut.raa[3] !== 8'd0) begin
      n_fail++;
      $display("FAIL ceil_raa_final: got %0d want 0", dut.raa[3]);
    end
  endtask

  task automatic test_act_during_wait();
    do_reset();
    for (int i = 0; i < 20; i++) do_act(2'd1);
    tick();
    for (int i = 0; i < 5; i++) tick();
    do_act(2'd1);
    n_assert++;
    if (bus.act_err !== 1'b1 || dut.raa[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL wait_granted_act: got err=%b raa1=%0d want 1/0", bus.act_err, dut.raa[1]);
    end
    do_act(2'd2);
    n_assert++;
    if (bus.act_err !== 1'b0 || dut.raa[2] !== 8'd1) begin
      n_fail++;
      $display("FAIL wait_other_act: got err=%b raa2=%0d want 0/1", bus.act_err, dut.raa[2]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int hits;
    do_reset();
    for (int i = 0; i < 5; i++) do_act(2'd1);
    for (int i = 0; i < 20; i++) do_act(2'd0);
    tick();
    for (int i = 0; i < 30; i++) tick();
    rstn = 1'b0;
    #1;
    n_assert++;
    if (bus.busy !== 1'b0 || bus.rfm_cmd !== 4'b0000 || bus.act_block !== 4'b0000 ||
        dut.raa[0] !== 8'd0 || dut.raa[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_async: got busy=%b cmd=%b blk=%b raa0=%0d raa1=%0d want 0",
               bus.busy, bus.rfm_cmd, bus.act_block, dut.raa[0], dut.raa[1]);
    end
    tick();
    rstn = 1'b1;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rfm_cmd !== 4'b0000 || bus.busy !== 1'b0) hits++;
      tick();
    end
    for (int i = 0; i < 19; i++) do_act(2'd0);
    for (int i = 0; i < 10; i++) begin
      if (bus.rfm_cmd !== 4'b0000) hits++;
      tick();
    end
    n_assert++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL rst_no_residual: got %0d active cycles want 0", hits);
    end
    do_act(2'd0);
    tick();
    n_assert++;
    if (bus.rfm_cmd !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_fresh_grant: got %b want 0001", bus.rfm_cmd);
    end
  endtask

  task automatic test_boundary();
    int hits;
    do_reset();
    for (int i = 0; i < 19; i++) do_act(2'd2);
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rfm_cmd !== 4'b0000) hits++;
      tick();
    end
    n_assert++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL bnd_19_acts: got %0d rfm cycles want 0", hits);
    end
    do_act(2'd2);
    n_assert++;
    if (bus.rfm_cmd !== 4'b0000) begin
      n_fail++;
      $display("FAIL bnd_grant_cycle: got %b want 0000", bus.rfm_cmd);
    end
    tick();
    n_assert++;
    if (bus.rfm_cmd !== 4'b0100) begin
      n_fail++;
      $display("FAIL bnd_20th: got %b want 0100", bus.rfm_cmd);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    rstn     = 1'b0;
    test_reset();
    test_threshold();
    test_round_robin();
    test_ceiling();
    test_act_during_wait();
    test_reset_mid_wait();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
